// File: rtl/button_debouncer_pkg.sv
// Shared state encodings and default sizing for the push-button debouncer.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_WAIT_L = 2'd3
  } db_state_e;

  localparam int STABLE_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT         = 8;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level: synchronise, require STABLE_CYCLES of agreement,
// then emit a registered level and single-cycle rise/fall pulses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The WAIT states count edges of agreement; any disagreement drops straight back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_WAIT_H;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_H: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_WAIT_L;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_L: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4.
module tb_button_debouncer;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic out;
  logic rise;
  logic fall;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .STABLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (btn),
    .out  (out),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick_chk(input string tag, input logic eo, input logic er, input logic ef);
    @(posedge clk);
    #1;
    chk({tag, ".out"}, out, eo);
    chk({tag, ".rise"}, rise, er);
    chk({tag, ".fall"}, fall, ef);
  endtask

  // First sampling edge of a held new level: old level for S+1 edges, new level and
  // its pulse on edge S+2, pulse gone on the edge after.
  task automatic transition(input string tag, input logic v);
    btn = v;
    repeat (S + 1) tick_chk({tag, ".wait"}, !v, 1'b0, 1'b0);
    tick_chk({tag, ".edge"}, v, v, !v);
    tick_chk({tag, ".after"}, v, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b1;
    repeat (3) tick_chk("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    transition("rst_release", 1'b1);
    transition("release", 1'b0);
    transition("press", 1'b1);
    transition("release2", 1'b0);

    // Bounce: 3 high, 1 low, then held high; rise comes 6 edges after the final hold.
    btn = 1'b1;
    repeat (3) tick_chk("bounce.hi", 1'b0, 1'b0, 1'b0);
    btn = 1'b0;
    tick_chk("bounce.lo", 1'b0, 1'b0, 1'b0);
    btn = 1'b1;
    repeat (S + 1) tick_chk("bounce.hold", 1'b0, 1'b0, 1'b0);
    tick_chk("bounce.rise", 1'b1, 1'b1, 1'b0);
    tick_chk("bounce.after", 1'b1, 1'b0, 1'b0);

    // Glitch low for S-1 cycles while out is high.
    btn = 1'b0;
    repeat (S - 1) tick_chk("glitch.lo", 1'b1, 1'b0, 1'b0);
    btn = 1'b1;
    repeat (S + 2) tick_chk("glitch.hold", 1'b1, 1'b0, 1'b0);

    // Toggling every cycle never settles.
    for (int i = 0; i < 16; i++) begin
      btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick_chk("toggle", 1'b1, 1'b0, 1'b0);
    end
    btn = 1'b1;
    repeat (S + 2) tick_chk("toggle.settle", 1'b1, 1'b0, 1'b0);

    transition("release3", 1'b0);

    // Reset while counting toward a rise discards the progress.
    btn = 1'b1;
    repeat (3) tick_chk("midcount", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick_chk("midcount.rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    transition("after_midrst", 1'b1);

    // Reset while out is high forces it low.
    rst = 1'b1;
    tick_chk("rst_high", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    transition("final", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
